// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with zero-cycle hits and a single-line fill handshake.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache #(
  parameter int ICLLEN = 128,
  parameter int NLINES = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rdy,
  output logic [31:0]       fetch_instr,
  input  logic              flush,
  output logic              mem_ldp,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ldr,
  input  logic [ICLLEN-1:0] mem_ldData,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WORDS  = ICLLEN / 32;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(NLINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              state_q, state_d;
  logic [NLINES-1:0]   valid_q;
  logic [TAG_W-1:0]    tag_q  [NLINES];
  logic [ICLLEN-1:0]   data_q [NLINES];
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                discard_q;

  logic [IDX_W-1:0]    idx, fill_idx;
  logic [TAG_W-1:0]    tag, fill_tag;
  logic [WSEL_W-1:0]   wsel;
  logic                hit, fill, miss_start;
  logic                addr_unused;

  assign idx         = fetch_addr[OFF_W +: IDX_W];
  assign tag         = fetch_addr[ADDR_W-1 -: TAG_W];
  assign wsel        = fetch_addr[2 +: WSEL_W];
  assign fill_idx    = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag    = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign addr_unused = ^fetch_addr[1:0];

  // A flush in the same cycle suppresses the hit so fetch never sees a line being invalidated.
  assign hit  = (state_q == IDLE) & fetch_req & ~flush & valid_q[idx] & (tag_q[idx] == tag);
  assign fill = (state_q == MISS) & mem_ldr;

  assign fetch_rdy   = hit;
  assign fetch_instr = hit ? data_q[idx][{wsel, 5'b0} +: 32] : 32'h0;
  assign mem_ldp     = (state_q == MISS);
  assign mem_addr    = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req && !hit && !flush) begin
          state_d    = MISS;
          miss_start = 1'b1;
        end
      end
      MISS: begin
        if (mem_ldr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // discard_q remembers a flush seen during an outstanding fill so the returned line stays invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        mem_addr_q <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        discard_q  <= 1'b0;
      end else if ((state_q == MISS) && flush) begin
        discard_q <= 1'b1;
      end
      if (flush)
        valid_q <= '0;
      else if (fill && !discard_q)
        valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fill_idx] <= mem_ldData;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= 32'h0;
      miss_q <= 32'h0;
    end else begin
      if (fetch_rdy)  hit_q  <= hit_q + 32'h1;
      if (miss_start) miss_q <= miss_q + 32'h1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 32'h0;
  assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations, then random
// traffic checked every cycle against a line-address-level model of the cache contents.
module tb_icache;
  localparam int NLINES = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = 32'h0;
  logic         fetch_rdy;
  logic [31:0]  fetch_instr;
  logic         flush = 1'b0;
  logic         mem_ldp;
  logic [31:0]  mem_addr;
  logic         mem_ldr = 1'b0;
  logic [127:0] mem_ldData = 128'h0;
  logic [31:0]  hit_cnt, miss_cnt;

  int errors = 0;
  int checks = 0;

  icache #(.ICLLEN(128), .NLINES(NLINES), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdy(fetch_rdy), .fetch_instr(fetch_instr), .flush(flush),
    .mem_ldp(mem_ldp), .mem_addr(mem_addr), .mem_ldr(mem_ldr),
    .mem_ldData(mem_ldData), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory: line 0 holds the known program, everything else is a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [127:0] line0;
    line0 = 128'h001080A3_003100B3_021081B3_00108093;
    if (a[31:4] == 28'h0) return line0[{a[3:2], 5'b0} +: 32];
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // Model: which line address each index holds, plus the outstanding fill (if any).
  bit          m_init = 0;
  bit          m_valid [NLINES];
  logic [27:0] m_line  [NLINES];
  bit          m_busy = 0;
  bit          m_discard = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_hits = 32'h0;
  logic [31:0] m_misses = 32'h0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int  idx;
    bit  hit;
    idx = int'(fetch_addr[5:4]);
    hit = !m_busy && fetch_req && !flush && m_valid[idx] && (m_line[idx] == fetch_addr[31:4]);
    if (m_init) begin
      check_output("fetch_rdy", {31'h0, fetch_rdy}, {31'h0, hit});
      check_output("fetch_instr", fetch_instr, hit ? mem_word(fetch_addr) : 32'h0);
      check_output("mem_ldp", {31'h0, mem_ldp}, {31'h0, m_busy});
      check_output("mem_addr", mem_addr, m_addr);
`ifdef ICACHE_STATS_EN
      check_output("hit_cnt", hit_cnt, m_hits);
      check_output("miss_cnt", miss_cnt, m_misses);
`else
      check_output("hit_cnt", hit_cnt, 32'h0);
      check_output("miss_cnt", miss_cnt, 32'h0);
`endif
    end
    if (rst) begin
      m_init = 1;
      m_busy = 0;
      m_discard = 0;
      m_addr = 32'h0;
      m_hits = 32'h0;
      m_misses = 32'h0;
      for (int i = 0; i < NLINES; i++) m_valid[i] = 0;
    end else begin
      if (hit) m_hits++;
      if (!m_busy) begin
        if (fetch_req && !hit && !flush) begin
          m_busy = 1;
          m_discard = 0;
          m_addr = {fetch_addr[31:4], 4'h0};
          m_misses++;
        end
      end else begin
        if (flush) m_discard = 1;
        if (mem_ldr) begin
          m_busy = 0;
          if (!m_discard) begin
            m_valid[int'(m_addr[5:4])] = 1;
            m_line[int'(m_addr[5:4])] = m_addr[31:4];
          end
        end
      end
      if (flush) for (int i = 0; i < NLINES; i++) m_valid[i] = 0;
    end
  end

  // Drives one cycle of inputs just after the edge and returns at the following falling edge.
  task automatic apply_stimulus(input bit r, input bit req, input logic [31:0] a,
                                input bit fl, input bit ldr);
    @(posedge clk);
    #1;
    rst        = r;
    fetch_req  = req;
    fetch_addr = a;
    flush      = fl;
    mem_ldr    = ldr;
    mem_ldData = (ldr && m_busy) ? mem_line(m_addr) : {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
  endtask

  initial begin
    bit          r, req, fl, ldr;
    logic [31:0] a;

    apply_stimulus(1, 0, 32'h0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0);

    // Cold miss at address 0, memory answers one cycle after ldp
    apply_stimulus(0, 1, 32'h0, 0, 0);
    check_output("cold_rdy_N", {31'h0, fetch_rdy}, 32'h0);
    check_output("cold_ldp_N", {31'h0, mem_ldp}, 32'h0);
    apply_stimulus(0, 1, 32'h0, 0, 0);
    check_output("cold_ldp_N1", {31'h0, mem_ldp}, 32'h1);
    check_output("cold_addr_N1", mem_addr, 32'h0);
    apply_stimulus(0, 1, 32'h0, 0, 1);
    apply_stimulus(0, 1, 32'h0, 0, 0);
    check_output("cold_rdy_N3", {31'h0, fetch_rdy}, 32'h1);
    check_output("cold_instr_N3", fetch_instr, 32'h00108093);

    apply_stimulus(0, 1, 32'h4, 0, 0);
    check_output("hit_instr_4", fetch_instr, 32'h021081B3);
    apply_stimulus(0, 1, 32'h8, 0, 0);
    check_output("hit_instr_8", fetch_instr, 32'h003100B3);
    apply_stimulus(0, 1, 32'hC, 0, 0);
    check_output("hit_instr_C", fetch_instr, 32'h001080A3);
    check_output("hit_ldp_C", {31'h0, mem_ldp}, 32'h0);
    apply_stimulus(0, 0, 32'hC, 0, 0);
`ifdef ICACHE_STATS_EN
    check_output("stats_hits", hit_cnt, 32'd4);
    check_output("stats_misses", miss_cnt, 32'd1);
`else
    check_output("stats_hits_off", hit_cnt, 32'd0);
    check_output("stats_misses_off", miss_cnt, 32'd0);
`endif

    // Conflict: 0x40 shares index 0 with 0x0
    apply_stimulus(0, 1, 32'h40, 0, 0);
    check_output("conf_rdy", {31'h0, fetch_rdy}, 32'h0);
    apply_stimulus(0, 1, 32'h40, 0, 0);
    check_output("conf_addr", mem_addr, 32'h40);
    apply_stimulus(0, 1, 32'h40, 0, 1);
    apply_stimulus(0, 1, 32'h40, 0, 0);
    check_output("conf_hit40", {31'h0, fetch_rdy}, 32'h1);
    apply_stimulus(0, 1, 32'h0, 0, 0);
    check_output("conf_remiss0", {31'h0, fetch_rdy}, 32'h0);
    apply_stimulus(0, 1, 32'h0, 0, 0);
    check_output("conf_ldp0", {31'h0, mem_ldp}, 32'h1);
    apply_stimulus(0, 1, 32'h0, 0, 1);

    // Flush while the fill is pending
    apply_stimulus(0, 1, 32'h80, 0, 0);
    apply_stimulus(0, 1, 32'h80, 1, 0);
    check_output("flush_ldp_held", {31'h0, mem_ldp}, 32'h1);
    apply_stimulus(0, 1, 32'h80, 0, 0);
    check_output("flush_ldp_wait", {31'h0, mem_ldp}, 32'h1);
    apply_stimulus(0, 1, 32'h80, 0, 1);
    apply_stimulus(0, 1, 32'h80, 0, 0);
    check_output("flush_remiss", {31'h0, fetch_rdy}, 32'h0);
    apply_stimulus(0, 1, 32'h80, 0, 0);
    check_output("flush_new_ldp", {31'h0, mem_ldp}, 32'h1);
    apply_stimulus(0, 1, 32'h80, 0, 1);
    apply_stimulus(0, 1, 32'h84, 0, 0);
    check_output("flush_refill_hit", {31'h0, fetch_rdy}, 32'h1);

    // Reset while a miss is outstanding, then a stray ldr
    apply_stimulus(0, 1, 32'h100, 0, 0);
    apply_stimulus(0, 1, 32'h100, 0, 0);
    apply_stimulus(1, 0, 32'h100, 0, 0);
    apply_stimulus(0, 0, 32'h100, 0, 1);
    check_output("rst_ldp_drop", {31'h0, mem_ldp}, 32'h0);
    check_output("rst_rdy", {31'h0, fetch_rdy}, 32'h0);
    apply_stimulus(0, 1, 32'h100, 0, 0);
    check_output("rst_still_miss", {31'h0, fetch_rdy}, 32'h0);
    apply_stimulus(0, 1, 32'h100, 0, 0);
    apply_stimulus(0, 1, 32'h100, 0, 1);

    // Random traffic over a small set of lines so hits, conflicts and refills all occur
    a = 32'h0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0)
        a = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) |
            (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
      r   = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      req = ($urandom_range(0, 3) != 0);
      ldr = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      apply_stimulus(r, req, a, fl, ldr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between instruction fetch and main memory.
- Serves 32-bit instruction words to fetch from cached ICLLEN-bit lines.
- On a miss, it acts as the consumer side of the data bus. It raises ldp with a line address, waits for the single-cycle ldr pulse, captures ldData and fills the line.

Parameters:
- ICLLEN, 128, cache line width in bits (4 instruction words).
- NLINES, 4, number of lines; power of two, >= 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- fetch_req  in  1  fetch requests the word at fetch_addr; level, held until fetch_rdy.
- fetch_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_rdy  out  1  fetch_instr valid this cycle (hit).
- fetch_instr  out  32  instruction word.
- flush  in  1  invalidate all lines.
- mem_ldp  out  1  line load pending (bus.ldp).
- mem_addr  out  ADDR_W  line-aligned fill address, bits [3:0] = 0.
- mem_ldr  in  1  line data ready, one-cycle pulse (bus.ldr).
- mem_ldData  in  ICLLEN  returned line (bus.ldData).
- hit_cnt  out  32  hit counter (optional feature).
- miss_cnt  out  32  miss counter (optional feature).

Behaviour:
- Address split:
  - word offset = fetch_addr[3:2]; word 0 = ldData[31:0], word 3 = ldData[127:96].
  - index = fetch_addr[4 +: log2(NLINES)].
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, ICLLEN data, all registers.
- Reset:
  - all valid bits = 0; state = IDLE.
  - fetch_rdy = 0, fetch_instr = 0, mem_ldp = 0, mem_addr = 0, counters = 0.
- FSM states: IDLE, MISS.
- IDLE:
  - Hit = fetch_req & valid[index] & tag match.
  - On hit: fetch_rdy = 1 combinationally in the same cycle; fetch_instr = selected word. Zero-cycle hit latency.
  - When fetch_rdy = 0, fetch_instr = 0.
  - On miss (fetch_req & !hit & !flush): latch line address into mem_addr; next state MISS.
- MISS:
  - mem_ldp = 1, decoded from state; mem_addr is held stable; fetch_rdy = 0.
  - mem_ldp stays high until mem_ldr is seen.
  - On mem_ldr = 1: write mem_ldData into the latched index, set tag, set valid = 1; next state IDLE.
- Miss timing (memory answers one cycle after ldp):
  - cycle N: miss detected.
  - N+1: ldp = 1.
  - N+2: ldr = 1, line written at the end of the cycle.
  - N+3: IDLE, hit, fetch_rdy = 1.
  - Miss penalty is 3 cycles.
- mem_ldr while in IDLE: ignored, no write.
- fetch_addr changing during MISS: the fill completes for the latched address only. Lookup in the following IDLE cycle uses the current fetch_addr, which may miss again.
- fetch_req = 0 during MISS: the fill still completes; the line is cached.
- flush:
  - Clears all valid bits at the clock edge; takes priority over any hit or fill in the same cycle.
  - In IDLE: fetch_rdy is forced to 0 that cycle and no miss is started.
  - In MISS: the handshake continues (mem_ldp held until mem_ldr), but the returned line is discarded and left invalid. No orphaned bus transaction.
- rst during MISS: state returns to IDLE and mem_ldp drops on the next cycle. Any late mem_ldr is ignored.
- Conflict misses: the new line overwrites the previous line at that index unconditionally.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_cnt increments by 1 each cycle fetch_rdy = 1.
  - miss_cnt increments by 1 on each IDLE->MISS transition.
  - Both are 32-bit wrapping counters (0xFFFFFFFF -> 0), cleared by rst, not cleared by flush.
- Undefined: hit_cnt and miss_cnt are tied to 0; no counter logic is synthesized.

Test Plan:
- Cold miss:
  - Stimulus: reset, then fetch_req = 1, fetch_addr = 0x00000000.
  - Memory returns line 128'h001080A3_003100B3_021081B3_00108093 one cycle after ldp.
  - Response: mem_ldp = 1 at N+1 with mem_addr = 0x0; fetch_rdy = 1 at N+3 with fetch_instr = 0x00108093.
- Hits on same line:
  - Stimulus: after the cold miss, fetch 0x4, 0x8, 0xC on consecutive cycles.
  - Response: fetch_rdy = 1 each cycle; instr = 0x021081B3, 0x003100B3, 0x001080A3; mem_ldp stays 0.
- Conflict miss:
  - Stimulus: with NLINES = 4, fetch 0x40, which maps to index 0 with a different tag.
  - Response: miss, mem_addr = 0x40. A subsequent fetch of 0x0 misses again.
- Flush mid-fill:
  - Stimulus: assert flush in the cycle mem_ldp = 1.
  - Response: mem_ldp held until ldr; after returning to IDLE, the same address misses again (new ldp).
- Reset mid-miss:
  - Stimulus: rst = 1 while in MISS.
  - Response: next cycle mem_ldp = 0, fetch_rdy = 0; a stray mem_ldr causes no fill; the address still misses afterward.
- Stats (ICACHE_STATS_EN):
  - Stimulus: cold-miss plus hits sequence.
  - Response: miss_cnt = 1, hit_cnt = 4. Without the macro, both read 0.
